// File: rtl/decode_stage_pkg.sv
// Shared RISC-V opcode constants, one-hot format bit positions and skid-buffer load selects
// for the decode stage.
package decode_stage_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_I_IMM    = 7'b0010011;
    localparam logic [6:0] OP_I_IMM_W  = 7'b0011011;
    localparam logic [6:0] OP_R        = 7'b0110011;
    localparam logic [6:0] OP_R_W      = 7'b0111011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam int FMT_I   = 0;
    localparam int FMT_U   = 1;
    localparam int FMT_J   = 2;
    localparam int FMT_B   = 3;
    localparam int FMT_S   = 4;
    localparam int FMT_SYS = 5;
    localparam int FMT_W   = 6;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IN   = 2'd1,
        SRC_SKID = 2'd2
    } out_src_e;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate/format decode for one RV32/RV64 instruction.
// DECODE_ILLEGAL_CHECK_EN enables the illegal-encoding detector; otherwise illegal is tied 0.
module decode_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]      ins,
    output logic [XLEN-1:0]  imm,
    output logic [FMT_W-1:0] fmt,
    output logic             illegal
);

    localparam logic RV64 = (XLEN == 64);

    logic [6:0] opcode_s;
    assign opcode_s = ins[6:0];

    // Format tag and extended immediate selected by opcode
    always_comb begin
        imm = {XLEN{1'b0}};
        fmt = {FMT_W{1'b0}};
        case (opcode_s)
            OP_JALR, OP_LOAD, OP_I_IMM, OP_MISC_MEM: begin
                imm        = XLEN'($signed(ins[31:20]));
                fmt[FMT_I] = 1'b1;
            end
            OP_I_IMM_W: begin
                if (RV64) begin
                    imm        = XLEN'($signed(ins[31:20]));
                    fmt[FMT_I] = 1'b1;
                end else begin
                    imm = {XLEN{1'b0}};
                    fmt = {FMT_W{1'b0}};
                end
            end
            OP_LUI, OP_AUIPC: begin
                imm        = XLEN'($signed({ins[31:12], 12'h000}));
                fmt[FMT_U] = 1'b1;
            end
            OP_JAL: begin
                imm        = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                fmt[FMT_J] = 1'b1;
            end
            OP_BRANCH: begin
                imm        = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                fmt[FMT_B] = 1'b1;
            end
            OP_STORE: begin
                imm        = XLEN'($signed({ins[31:25], ins[11:7]}));
                fmt[FMT_S] = 1'b1;
            end
            OP_SYSTEM: begin
                imm          = XLEN'(ins[31:20]);
                fmt[FMT_SYS] = 1'b1;
            end
            default: begin
                imm = {XLEN{1'b0}};
                fmt = {FMT_W{1'b0}};
            end
        endcase
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    function automatic logic is_illegal(input logic [31:0] i);
        logic       bad;
        logic [2:0] f3;
        logic [6:0] f7;
        f3  = i[14:12];
        f7  = i[31:25];
        bad = 1'b0;
        if (i[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (i[6:0])
                OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                OP_MISC_MEM, OP_SYSTEM: bad = 1'b0;
                // RV64 shift amounts are 6 bits wide, so only ins[31:26] carry the funct code
                OP_I_IMM: begin
                    if (f3 == 3'b001) begin
                        bad = RV64 ? (i[31:26] != 6'b000000) : (f7 != 7'b0000000);
                    end else if (f3 == 3'b101) begin
                        bad = RV64 ? (i[31:26] != 6'b000000 && i[31:26] != 6'b010000)
                                   : (f7 != 7'b0000000 && f7 != 7'b0100000);
                    end else begin
                        bad = 1'b0;
                    end
                end
                OP_R: bad = !(f7 == 7'b0000000 ||
                              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                OP_I_IMM_W: begin
                    if (!RV64) begin
                        bad = 1'b1;
                    end else if (f3 == 3'b000) begin
                        bad = 1'b0;
                    end else if (f3 == 3'b001) begin
                        bad = (f7 != 7'b0000000);
                    end else if (f3 == 3'b101) begin
                        bad = (f7 != 7'b0000000 && f7 != 7'b0100000);
                    end else begin
                        bad = 1'b1;
                    end
                end
                OP_R_W: begin
                    if (!RV64) begin
                        bad = 1'b1;
                    end else begin
                        case (f3)
                            3'b000, 3'b101: bad = (f7 != 7'b0000000 && f7 != 7'b0100000);
                            3'b001:         bad = (f7 != 7'b0000000);
                            default:        bad = 1'b1;
                        endcase
                    end
                end
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    assign illegal = is_illegal(ins);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry (OUT + SKID) buffer so in_ready comes from a flop.
// Illegal-encoding detection is built only when DECODE_ILLEGAL_CHECK_EN is defined.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] imm,
    output logic [5:0]      fmt,
    output logic            illegal
);

    logic [XLEN-1:0]  gen_imm_s;
    logic [FMT_W-1:0] gen_fmt_s;
    logic             gen_illegal_s;

    decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .ins     (in_ins),
        .imm     (gen_imm_s),
        .fmt     (gen_fmt_s),
        .illegal (gen_illegal_s)
    );

    logic             out_valid_r, skid_valid_r, in_ready_r;
    logic [PC_W-1:0]  out_pc_r, skid_pc_r;
    logic [31:0]      out_ins_r, skid_ins_r;
    logic [XLEN-1:0]  out_imm_r, skid_imm_r;
    logic [FMT_W-1:0] out_fmt_r, skid_fmt_r;
    logic             out_illegal_r, skid_illegal_r;

    logic     accept_s, release_s, skid_load_s;
    logic     out_valid_nxt_s, skid_valid_nxt_s;
    out_src_e out_src_s;

    assign accept_s  = in_valid & in_ready_r;
    assign release_s = out_valid_r & out_ready;

    // Next occupancy and load select; SKID always drains into OUT before new input
    always_comb begin
        out_src_s        = SRC_NONE;
        skid_load_s      = 1'b0;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (!out_valid_r || release_s) begin
            if (skid_valid_r) begin
                out_src_s        = SRC_SKID;
                out_valid_nxt_s  = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                out_src_s       = SRC_IN;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_load_s      = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_load_s = 1'b0;
            end
        end
    end

    // Entry state and payload registers; flush drops occupancy but keeps payload
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            skid_valid_r   <= 1'b0;
            in_ready_r     <= 1'b1;
            out_pc_r       <= {PC_W{1'b0}};
            out_ins_r      <= 32'h0000_0000;
            out_imm_r      <= {XLEN{1'b0}};
            out_fmt_r      <= {FMT_W{1'b0}};
            out_illegal_r  <= 1'b0;
            skid_pc_r      <= {PC_W{1'b0}};
            skid_ins_r     <= 32'h0000_0000;
            skid_imm_r     <= {XLEN{1'b0}};
            skid_fmt_r     <= {FMT_W{1'b0}};
            skid_illegal_r <= 1'b0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
            case (out_src_s)
                SRC_IN: begin
                    out_pc_r      <= in_pc;
                    out_ins_r     <= in_ins;
                    out_imm_r     <= gen_imm_s;
                    out_fmt_r     <= gen_fmt_s;
                    out_illegal_r <= gen_illegal_s;
                end
                SRC_SKID: begin
                    out_pc_r      <= skid_pc_r;
                    out_ins_r     <= skid_ins_r;
                    out_imm_r     <= skid_imm_r;
                    out_fmt_r     <= skid_fmt_r;
                    out_illegal_r <= skid_illegal_r;
                end
                default: begin
                    out_pc_r      <= out_pc_r;
                    out_ins_r     <= out_ins_r;
                    out_imm_r     <= out_imm_r;
                    out_fmt_r     <= out_fmt_r;
                    out_illegal_r <= out_illegal_r;
                end
            endcase
            if (skid_load_s) begin
                skid_pc_r      <= in_pc;
                skid_ins_r     <= in_ins;
                skid_imm_r     <= gen_imm_s;
                skid_fmt_r     <= gen_fmt_s;
                skid_illegal_r <= gen_illegal_s;
            end else begin
                skid_pc_r      <= skid_pc_r;
                skid_ins_r     <= skid_ins_r;
                skid_imm_r     <= skid_imm_r;
                skid_fmt_r     <= skid_fmt_r;
                skid_illegal_r <= skid_illegal_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_pc    = out_pc_r;
    assign opcode    = out_ins_r[6:0];
    assign funct3    = out_ins_r[14:12];
    assign funct7    = out_ins_r[31:25];
    assign rs1       = out_ins_r[19:15];
    assign rs2       = out_ins_r[24:20];
    assign rd        = out_ins_r[11:7];
    assign csr_addr  = out_ins_r[31:20];
    assign imm       = out_imm_r;
    assign fmt       = out_fmt_r;
    assign illegal   = out_illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (XLEN=64): directed vectors plus randomized traffic
// checked against a queue-based reference of the two-entry stage.
module tb_decode_stage;

    localparam int XLEN = 64;
    localparam int PC_W = 64;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0]     in_ins;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] imm;
    logic [5:0]      fmt;

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ins(in_ins), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1),
        .rs2(rs2), .rd(rd), .csr_addr(csr_addr), .imm(imm), .fmt(fmt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } item_t;

    item_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural immediate/format rules, written as field concatenation + sign extension
    function automatic void ref_decode(input logic [31:0] ins, output logic [63:0] rimm,
                                       output logic [5:0] rfmt);
        longint signed v;
        logic [6:0]    op;
        op   = ins[6:0];
        rimm = 64'h0;
        rfmt = 6'b000000;
        case (op)
            7'h03, 7'h0F, 7'h13, 7'h1B, 7'h67: begin
                v = $signed(ins[31:20]); rimm = v; rfmt = 6'b000001;
            end
            7'h37, 7'h17: begin
                v = $signed({ins[31:12], 12'h000}); rimm = v; rfmt = 6'b000010;
            end
            7'h6F: begin
                v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); rimm = v; rfmt = 6'b000100;
            end
            7'h63: begin
                v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); rimm = v; rfmt = 6'b001000;
            end
            7'h23: begin
                v = $signed({ins[31:25], ins[11:7]}); rimm = v; rfmt = 6'b010000;
            end
            7'h73: begin
                rimm = {52'h0, ins[31:20]}; rfmt = 6'b100000;
            end
            default: begin
                rimm = 64'h0; rfmt = 6'b000000;
            end
        endcase
    endfunction

    // One clock: drive, compare against the model at negedge, advance the model at posedge
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic rdy, input logic fl, input logic rst, output logic acc);
        logic        exp_ready, exp_ov;
        logic [63:0] rimm;
        logic [5:0]  rfmt;
        item_t       it;
        in_valid = v; in_ins = ins; in_pc = pc; out_ready = rdy; flush = fl; rst_n = rst;
        @(negedge clk);
        exp_ready = (q.size() < 2);
        exp_ov    = (q.size() > 0);
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov && out_valid) begin
            it = q[0];
            ref_decode(it.ins, rimm, rfmt);
            check("out_pc", out_pc, it.pc);
            check("opcode", opcode, it.ins[6:0]);
            check("funct3", funct3, it.ins[14:12]);
            check("funct7", funct7, it.ins[31:25]);
            check("rs1", rs1, it.ins[19:15]);
            check("rs2", rs2, it.ins[24:20]);
            check("rd", rd, it.ins[11:7]);
            check("csr_addr", csr_addr, it.ins[31:20]);
            check("imm", imm, rimm);
            check("fmt", fmt, rfmt);
`ifndef DECODE_ILLEGAL_CHECK_EN
            check("illegal_off", illegal, 1'b0);
`endif
        end
        @(posedge clk);
        acc = v && exp_ready;
        it.ins = ins;
        it.pc  = pc;
        if (!rst || fl) begin
            q.delete();
        end else begin
            if (exp_ov && rdy) void'(q.pop_front());
            if (v && exp_ready) q.push_back(it);
        end
        #1;
    endtask

    task automatic send(input logic [31:0] ins, output logic acc);
        cycle(1'b1, ins, {32'h0000_1000, ins}, 1'b1, 1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 6 && q.size() > 0; k++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1, acc);
        check("drained", q.size(), 0);
    endtask

    logic [31:0] ops [13] = '{32'h03, 32'h0F, 32'h13, 32'h1B, 32'h67, 32'h37, 32'h17,
                               32'h6F, 32'h63, 32'h23, 32'h73, 32'h33, 32'h3B};

    initial begin
        logic        acc;
        logic [31:0] cur, r;
        logic [63:0] cur_pc;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ins = 32'h0; in_pc = 64'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_imm", imm, 64'h0);
        check("rst_fmt", fmt, 6'h0);
        check("rst_pc", out_pc, 64'h0);
        check("rst_rd", rd, 5'h0);

        // Known encodings with hand-derived results, one cycle after acceptance
        send(32'hFFF0_0093, acc);
        check("addi_rd", rd, 5'd1);
        check("addi_rs1", rs1, 5'd0);
        check("addi_fmt", fmt, 6'b000001);
        check("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h8000_0137, acc);
        check("lui_imm", imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_fmt", fmt, 6'b000010);
        send(32'hFFDF_F06F, acc);
        check("jal_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("jal_fmt", fmt, 6'b000100);
        send(32'h3050_9073, acc);
        check("csr_addr_v", csr_addr, 12'h305);
        check("csr_imm", imm, 64'h305);
        check("csr_fmt", fmt, 6'b100000);
        drain();

        // Backpressure: A,B fill OUT+SKID, C must wait
        cycle(1'b1, 32'h0010_0093, 64'hA0, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 32'h0020_0113, 64'hB0, 1'b0, 1'b0, 1'b1, acc);
        check("skid_full_ready", in_ready, 1'b0);
        cycle(1'b1, 32'h0030_0193, 64'hC0, 1'b0, 1'b0, 1'b1, acc);
        check("c_held", acc, 1'b0);
        cycle(1'b1, 32'h0030_0193, 64'hC0, 1'b0, 1'b0, 1'b1, acc);
        check("a_held_pc", out_pc, 64'hA0);
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) cycle(1'b1, 32'h0030_0193, 64'hC0, 1'b1, 1'b0, 1'b1, acc);
        check("c_accepted", acc, 1'b1);
        drain();

        // Flush with both entries full and a new instruction offered
        cycle(1'b1, 32'h0040_0213, 64'hD0, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 32'h0050_0293, 64'hE0, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 32'h0060_0313, 64'hF0, 1'b0, 1'b1, 1'b1, acc);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1, acc);

        // Reset dominates mid-stream traffic
        cycle(1'b1, 32'h0070_0393, 64'h100, 1'b0, 1'b0, 1'b1, acc);
        cycle(1'b1, 32'h0080_0413, 64'h108, 1'b0, 1'b1, 1'b0, acc);
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_imm", imm, 64'h0);

`ifdef DECODE_ILLEGAL_CHECK_EN
        send(32'h0000_0000, acc);
        check("illegal_zero", illegal, 1'b1);
        send(32'h0000_0013, acc);
        check("illegal_nop", illegal, 1'b0);
        drain();
`endif

        // Randomized traffic with valid held until accepted
        r      = $urandom();
        cur    = {r[31:7], ops[0][6:0]};
        cur_pc = {$urandom(), $urandom()};
        for (int n = 0; n < 400; n++) begin
            logic v, rdy, fl, rst;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 99) != 0);
            cycle(v, cur, cur_pc, rdy, fl, rst, acc);
            if (acc) begin
                r = $urandom();
                if ($urandom_range(0, 9) == 0) cur = r;
                else cur = {r[31:7], ops[$urandom_range(0, 12)][6:0]};
                cur_pc = {$urandom(), $urandom()};
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
